pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage core. Merges per-stage stall requests into the
//  per-register stall vector that drives pc, if_id, id_ex, ex_mem and mem_wb, and sequences
//  exception flushes, including the redirect PC. Also keeps a saturating stall-cycle counter and a
//  stuck-stall watchdog.
// PARAMETERS
//  FLUSH_LEN  1   cycles flush stays high per accepted exception (>=1)
//  MAX_STALL  64  consecutive stall cycles that set stall_timeout (>=1)
//  CNT_W      32  width of stall_cnt
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  rst_           in   1      reset; asynchronous, active-high; one clock domain
//  stallreq_if    in   1      fetch not ready (icache miss)
//  stallreq_id    in   1      decode hazard (load-use)
//  stallreq_ex    in   1      execute busy (multi-cycle mul/div/madd)
//  stallreq_mem   in   1      memory not ready (dcache miss)
//  excp_req       in   1      exception/ERET taken; single-cycle pulse
//  excp_pc        in   32     handler/return PC; valid with excp_req
//  stall          out  6      [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb [5]=wb
//  flush          out  1      clear all pipeline registers and load new_pc
//  new_pc         out  32     redirect PC; valid while flush=1
//  stall_cnt      out  CNT_W  total cycles with stall!=0; saturates at all-ones
//  stall_timeout  out  1      sticky: a stall run reached MAX_STALL
// BEHAVIOUR
//  - Reset (async, any state): state=RUN, stall=0, flush=0, new_pc=0, stall_cnt=0,
//    stall_timeout=0, run_len=0, flush_left=0. Reset during FLUSH ends the flush immediately.
//  - States: RUN, FLUSH.
//  - stall is combinational and has zero latency from the requests. It is forced to 0 in FLUSH.
//    In RUN, the deepest active requester selects the vector:
//      mem 6'b011111 > ex 6'b001111 > id 6'b000111 > if 6'b000011 > none 6'b000000.
//    Consumer rule: stall[k]=1 with stall[k+1]=0 inserts a bubble downstream.
//  - RUN & excp_req: latch new_pc<=excp_pc, flush<=1, flush_left<=FLUSH_LEN-1, go to FLUSH.
//    stall is still driven from the requests in that cycle. Flush beats any concurrent stall.
//  - FLUSH: flush=1 and new_pc is held constant. While flush_left>0, decrement it each cycle.
//    When flush_left=0, flush<=0 and state returns to RUN on the next edge. excp_req arriving
//    in FLUSH is dropped.
//  - Latency: excp_req in cycle N gives flush=1 in cycles N+1..N+FLUSH_LEN. First possible
//    nonzero stall is in cycle N+FLUSH_LEN+1.
//  - stall_cnt: +1 on each edge where stall!=0; holds at 2^CNT_W-1 (no wrap).
//  - run_len: +1 on each edge where stall!=0, saturating at MAX_STALL. Cleared on each edge where
//    stall==0 and on entering FLUSH. stall_timeout<=1 when run_len+1==MAX_STALL with stall!=0.
//    stall_timeout clears only on reset.
//  - Requests toggling mid-stall: the vector follows them in the same cycle; run_len keeps
//    counting while any request is active.
// STRUCTURE
//  - pipe_ctrl_pkg: state enum (RUN, FLUSH); stall-vector constants STALL_NONE, STALL_IF,
//    STALL_ID, STALL_EX, STALL_MEM; stage index constants.
//  - One sub-module, sat_cnt #(W): saturating up-counter with inc and clr inputs. It is
//    instantiated twice: stall_cnt, and run_len sized $clog2(MAX_STALL+1).
//  - Priority encode and FSM are inline.
// TESTING
//  1. Reset with every request high: outputs all 0. Release reset with no requests: stall=0.
//  2. stallreq_id=1 for 3 cycles, with stallreq_ex=1 in the middle cycle:
//     stall=000111, 001111, 000111; stall_cnt=3.
//  3. excp_req=1 with excp_pc=32'hBFC00380 while stallreq_mem=1, FLUSH_LEN=2: stall=011111 that
//     cycle; then 2 cycles of flush=1 with new_pc=BFC00380 and stall=0; then RUN.
//  4. Second excp_req during FLUSH (excp_pc=32'h80000180): dropped; new_pc stays BFC00380.
//  5. stallreq_ex held for 64 cycles, MAX_STALL=64: stall_timeout rises after edge 64 and stays
//     1 after the request drops.
//  6. CNT_W=4, 20 stall cycles: stall_cnt sticks at 4'hF. Async reset mid-FLUSH: flush drops
//     without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared types and constants for the pipeline sequencer: FSM state
//   encoding, per-requester stall vectors and stall-vector bit indices.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int STALL_W = 6;

    // Bit positions of the stall vector, one per pipeline register.
    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;
    localparam int STG_WB     = 5;

    // A requester freezes its own stage and everything upstream of it.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// sat_cnt
//   Saturating up-counter. clr has priority over inc; the count holds at MAX.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     inc       count up by one this edge (unless saturated)
//     clr       clear to zero this edge
//     cnt       current count
module sat_cnt #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline sequencer for the 5-stage core: merges stage stall requests into
//   the per-register stall vector, sequences exception flushes with the
//   redirect PC, counts stall cycles and flags stuck stalls.
//   Ports:
//     clk, rst_       clock, asynchronous active-high reset
//     stallreq_*      stall requests from if / id / ex / mem
//     excp_req        exception taken (single-cycle pulse), excp_pc its target
//     stall           per-register stall vector (combinational)
//     flush           clear pipeline registers and load new_pc
//     new_pc          redirect PC, held while flush is high
//     stall_cnt       saturating count of cycles with any stall
//     stall_timeout   sticky: a stall run reached MAX_STALL cycles
//
//   state    | meaning
//   ST_RUN   | normal operation, stall follows the requests
//   ST_FLUSH | flush asserted, stall forced to 0, new exceptions dropped
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_LEN = 1,
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               excp_req,
    input  logic [31:0]        excp_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               stall_timeout
);

    localparam int FL_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int RL_W = $clog2(MAX_STALL + 1);

    state_e            state_q, state_d;
    logic [FL_W-1:0]   flush_left_q, flush_left_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic              timeout_q, timeout_d;
    logic [RL_W-1:0]   run_len;
    logic              stall_nz;
    logic              enter_flush;

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        new_pc_d     = new_pc_q;
        enter_flush  = 1'b0;
        stall        = STALL_NONE;

        // Reset also masks the vector so nothing downstream moves while held.
        if (!rst_ && state_q == ST_RUN) begin
            if (stallreq_mem)      stall = STALL_MEM;
            else if (stallreq_ex)  stall = STALL_EX;
            else if (stallreq_id)  stall = STALL_ID;
            else if (stallreq_if)  stall = STALL_IF;
        end

        case (state_q)
            ST_RUN: begin
                if (excp_req) begin
                    enter_flush  = 1'b1;
                    new_pc_d     = excp_pc;
                    flush_left_d = FL_W'(FLUSH_LEN - 1);
                    state_d      = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_left_q != '0) begin
                    flush_left_d = flush_left_q - FL_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign stall_nz  = (stall != STALL_NONE);
    assign timeout_d = timeout_q | (stall_nz && (int'(run_len) + 1 == MAX_STALL));

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q      <= ST_RUN;
            flush_left_q <= '0;
            new_pc_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            new_pc_q     <= new_pc_d;
            timeout_q    <= timeout_d;
        end
    end

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst_),
        .inc (stall_nz),
        .clr (1'b0),
        .cnt (stall_cnt)
    );

    // Run length of the current stall; restarts on any stall-free cycle or flush.
    sat_cnt #(.W(RL_W), .MAX(RL_W'(MAX_STALL))) u_run_len (
        .clk (clk),
        .rst (rst_),
        .inc (stall_nz),
        .clr (!stall_nz || enter_flush),
        .cnt (run_len)
    );

    assign flush         = (state_q == ST_FLUSH);
    assign new_pc        = new_pc_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int FLUSH_LEN = 2;
    localparam int MAX_STALL = 64;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        sr_if = 1'b0, sr_id = 1'b0, sr_ex = 1'b0, sr_mem = 1'b0;
    logic        excp_req = 1'b0;
    logic [31:0] excp_pc = '0;

    logic [5:0]  stall, stall4;
    logic        flush, flush4;
    logic [31:0] new_pc, new_pc4;
    logic [31:0] stall_cnt;
    logic [3:0]  stall_cnt4;
    logic        stall_timeout, stall_timeout4;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(.FLUSH_LEN(FLUSH_LEN), .MAX_STALL(MAX_STALL), .CNT_W(32)) u_dut (
        .clk(clk), .rst_(rst_),
        .stallreq_if(sr_if), .stallreq_id(sr_id), .stallreq_ex(sr_ex), .stallreq_mem(sr_mem),
        .excp_req(excp_req), .excp_pc(excp_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
    );

    pipe_ctrl #(.FLUSH_LEN(FLUSH_LEN), .MAX_STALL(MAX_STALL), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_(rst_),
        .stallreq_if(sr_if), .stallreq_id(sr_id), .stallreq_ex(sr_ex), .stallreq_mem(sr_mem),
        .excp_req(excp_req), .excp_pc(excp_pc),
        .stall(stall4), .flush(flush4), .new_pc(new_pc4),
        .stall_cnt(stall_cnt4), .stall_timeout(stall_timeout4)
    );

    always #5 clk = ~clk;

    // Reference model: flush cycles remaining, redirect PC, counters.
    int      m_flush_left;
    logic [31:0] m_pc;
    longint  m_cnt;
    int      m_cnt4;
    int      m_run;
    logic    m_to;
    logic [5:0] obs_stall;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] model_stall();
        int depth;
        if (rst_ || m_flush_left > 0) return 6'd0;
        depth = sr_mem ? 4 : sr_ex ? 3 : sr_id ? 2 : sr_if ? 1 : 0;
        if (depth == 0) return 6'd0;
        return 6'((1 << (depth + 1)) - 1);
    endfunction

    task automatic model_reset();
        m_flush_left = 0; m_pc = '0; m_cnt = 0; m_cnt4 = 0; m_run = 0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] s);
        logic nz;
        nz = (s != 0);
        if (nz) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
            if (m_run + 1 == MAX_STALL) m_to = 1'b1;
        end
        if (m_flush_left > 0) begin
            m_flush_left--;
            m_run = nz ? ((m_run < MAX_STALL) ? m_run + 1 : m_run) : 0;
        end else if (excp_req) begin
            m_flush_left = FLUSH_LEN;
            m_pc = excp_pc;
            m_run = 0;
        end else begin
            m_run = nz ? ((m_run < MAX_STALL) ? m_run + 1 : m_run) : 0;
        end
    endtask

    task automatic check_regs();
        chk("flush", flush, m_flush_left > 0);
        chk("flush4", flush4, m_flush_left > 0);
        if (m_flush_left > 0) chk("new_pc", new_pc, m_pc);
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("stall_cnt4", stall_cnt4, m_cnt4);
        chk("stall_timeout", stall_timeout, m_to);
    endtask

    // Called at posedge+1: drive, check comb stall, clock, check registers.
    task automatic cyc(input logic [3:0] req, input logic ex, input logic [31:0] pc);
        logic [5:0] es;
        {sr_mem, sr_ex, sr_id, sr_if} = req;
        excp_req = ex;
        excp_pc  = pc;
        #2;
        es = model_stall();
        obs_stall = stall;
        chk("stall", stall, es);
        chk("stall4", stall4, es);
        @(posedge clk);
        model_step(es);
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        {sr_mem, sr_ex, sr_id, sr_if} = 4'b0;
        excp_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_ = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;   // {mem, ex, id, if}
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'b0000, 6'b000000};
        vecs[1] = '{4'b0001, 6'b000011};
        vecs[2] = '{4'b0010, 6'b000111};
        vecs[3] = '{4'b0011, 6'b000111};
        vecs[4] = '{4'b0100, 6'b001111};
        vecs[5] = '{4'b0111, 6'b001111};
        vecs[6] = '{4'b1000, 6'b011111};
        vecs[7] = '{4'b1111, 6'b011111};
        vecs[8] = '{4'b1010, 6'b011111};
        vecs[9] = '{4'b0101, 6'b001111};

        // 1. reset with all requests high
        model_reset();
        {sr_mem, sr_ex, sr_id, sr_if} = 4'b1111;
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_new_pc", new_pc, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_timeout", stall_timeout, 0);
        @(posedge clk); #1;
        {sr_mem, sr_ex, sr_id, sr_if} = 4'b0000;
        rst_ = 1'b0;
        cyc(4'b0000, 1'b0, '0);
        chk("idle_stall", obs_stall, 6'b000000);

        // 2. id stall with ex in the middle
        cyc(4'b0010, 1'b0, '0); chk("seq_id0", obs_stall, 6'b000111);
        cyc(4'b0110, 1'b0, '0); chk("seq_ex",  obs_stall, 6'b001111);
        cyc(4'b0010, 1'b0, '0); chk("seq_id1", obs_stall, 6'b000111);
        chk("seq_cnt", stall_cnt, 3);

        // priority table
        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].req, 1'b0, '0);
            chk("tbl_stall", obs_stall, vecs[i].exp);
        end

        // 3/4. exception during mem stall, second exception dropped
        cyc(4'b1000, 1'b1, 32'hBFC00380);
        chk("ex_stall_same_cycle", obs_stall, 6'b011111);
        chk("ex_flush1", flush, 1);
        chk("ex_pc1", new_pc, 32'hBFC00380);
        cyc(4'b1000, 1'b1, 32'h80000180);
        chk("ex_stall_in_flush", obs_stall, 6'b000000);
        chk("ex_flush2", flush, 1);
        chk("ex_pc_drop", new_pc, 32'hBFC00380);
        cyc(4'b1000, 1'b0, '0);
        chk("ex_stall_in_flush2", obs_stall, 6'b000000);
        chk("ex_flush_end", flush, 0);
        cyc(4'b1000, 1'b0, '0);
        chk("ex_run_stall", obs_stall, 6'b011111);

        // 5. watchdog
        do_reset();
        for (int i = 0; i < 63; i++) cyc(4'b0100, 1'b0, '0);
        chk("wd_before", stall_timeout, 0);
        cyc(4'b0100, 1'b0, '0);
        chk("wd_set", stall_timeout, 1);
        cyc(4'b0000, 1'b0, '0);
        chk("wd_sticky", stall_timeout, 1);

        // 6. 4-bit counter saturation, async reset mid-flush
        do_reset();
        for (int i = 0; i < 20; i++) cyc(4'b0001, 1'b0, '0);
        chk("sat_cnt4", stall_cnt4, 4'hF);
        chk("sat_cnt32", stall_cnt, 20);
        cyc(4'b0000, 1'b1, 32'h1234_5678);
        chk("arst_flush_pre", flush, 1);
        #2;
        rst_ = 1'b1;
        #1;
        chk("arst_flush", flush, 0);
        chk("arst_new_pc", new_pc, 0);
        chk("arst_cnt", stall_cnt, 0);
        model_reset();
        @(posedge clk); #1;
        rst_ = 1'b0;

        // randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] r;
            r[0] = ($urandom_range(0, 3) == 0);
            r[1] = ($urandom_range(0, 4) == 0);
            r[2] = ($urandom_range(0, 5) == 0);
            r[3] = ($urandom_range(0, 6) == 0);
            if (i >= 700 && i < 800) r[2] = 1'b1;
            cyc(r, ($urandom_range(0, 15) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
